ldpc_bitflip_decode: RTL and testbench
======================================

# ldpc_bitflip_decode

Hard-decision Gallager bit-flipping decoder for the systematic (N, K) LDPC code produced by the `encode` block. It sits at the receive end of the link. It takes one N-bit received word and the flattened parity-check matrix H, then iterates syndrome check and flip passes until the syndrome is zero or the iteration budget runs out. It returns the K recovered information bits with a pass/fail flag and the number of iterations used.

## Interface
- `N`, 11, codeword length in bits.
- `K`, 6, information length; the block has M = N-K parity checks.
- `MAX_ITER`, 8, maximum number of flip iterations (at least 1).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `i_en` input 1: start strobe; sampled only in IDLE.
- `codeword_in` input N: received hard-decision word; bit j is codeword bit j.
- `parity_check` input M*N: H in row-major order; row r is `parity_check[(M-r)*N-1 -: N]`, and slice bit j is the coefficient of codeword bit j.
- `info_bits` output K: decoded information bits, equal to the corrected word's bits [N-1:N-K].
- `o_valid` output 1: one-cycle pulse when a result is posted.
- `o_success` output 1: 1 means the final syndrome was zero; holds until the next start.
- `o_busy` output 1: high from the start capture until DONE is left.
- `iter_count` output $clog2(MAX_ITER+1): number of flip iterations performed; holds until the next start.

## Operation
- Internal registers:
  - `c` (N bits): working word.
  - `h` (M*N bits): latched H.
  - `iter`: iteration counter.
  - state: one of IDLE, SYND, FLIP, DONE.
- IDLE: on `i_en`=1, latch `codeword_in` into `c`, latch `parity_check` into `h`, clear `iter`, and go to SYND. Both inputs may change freely after the capture edge.
- Syndrome: `s[r]` = XOR over j of (`c[j]` & `h[r][j]`). It is combinational from the registers.
- SYND:
  - If s == 0, go to DONE with success = 1.
  - Else if `iter` == MAX_ITER, go to DONE with success = 0.
  - Else go to FLIP.
- FLIP:
  - For each bit, the unsatisfied count is u_j = popcount(s & column j of h). Its width is $clog2(M+1), with no overflow possible.
  - umax = max over j of u_j; umax ≥ 1 is guaranteed because s ≠ 0.
  - Invert every `c[j]` with u_j == umax. All tied bits flip in the same cycle.
  - `iter` += 1, then go to SYND.
- DONE:
  - Register `info_bits` = `c[N-1:N-K]`, `o_success`, and `iter_count` = `iter`.
  - Pulse `o_valid` and return to IDLE.
- `i_en` is ignored in SYND, FLIP and DONE. There is no queuing.
- Reset (`rst_n`=0 at a rising edge) overrides everything, including mid-decode:
  - state goes to IDLE;
  - `c`, `h`, `iter` are cleared;
  - all outputs go to 0.
  - No `o_valid` is produced for an aborted word.

## Timing
- Reset values: `info_bits`=0, `o_valid`=0, `o_success`=0, `o_busy`=0, `iter_count`=0.
- Latency: if `i_en` is sampled at edge E0, `o_valid` is high during the cycle after edge E0+2+2k, where k is the number of iterations. Examples:
  - error-free word: E0+2;
  - failure: E0+2+2·MAX_ITER.
- `o_busy` is high from edge E0+1 through the `o_valid` cycle, and low the cycle after.
- Back-to-back operation: `i_en` held high is accepted again on the edge that leaves DONE, which is the `o_valid` cycle edge. Throughput is therefore one word every 3+2k cycles.
- `o_valid` is asserted for exactly one cycle. `info_bits`, `o_success` and `iter_count` are stable from that cycle until the next DONE or reset.
- The block is fully synchronous and has no combinational input-to-output paths.

## Test plan
All scenarios use the defaults N=11, K=6, MAX_ITER=8.

- **Clean word.** H rows r=0..4 = 1<<(10-r), `codeword_in`=0, `i_en` pulsed → `o_valid` 2 cycles after capture, `o_success`=1, `iter_count`=0, `info_bits`=6'b000000.
- **Single info-bit error.** Same H, `codeword_in`=11'b10000000000 → `o_valid` 4 cycles after capture, `o_success`=1, `iter_count`=1, `info_bits`=6'b000000.
- **Double error with tie flip.** Same H, `codeword_in`=11'b10010000000 → both bits flip in one FLIP, `o_success`=1, `iter_count`=1, `info_bits`=0.
- **Oscillating failure.** H row 0 = 11'b00000000011 and other rows 0, `codeword_in`=11'b00000000001 → the word alternates between 0x001 and 0x002. `o_valid` arrives 18 cycles after capture with `o_success`=0, `iter_count`=8, `info_bits`=0.
- **Busy and H latching.**
  - Start scenario 2, then change `parity_check` to all-ones and pulse `i_en` during FLIP. The result is unchanged from scenario 2.
  - Exactly one `o_valid` is produced.
  - `i_en` held high through DONE starts the next decode, and `o_busy` stays high.
- **Reset mid-decode.** Drive `rst_n`=0 for one edge while in FLIP of scenario 4. All outputs read 0 the next cycle, no `o_valid` appears, and a fresh scenario-1 decode afterwards returns `o_success`=1.

Source files
------------

// File: rtl/ldpc_bitflip_decode_if.sv
// Bus bundle for the bit-flipping LDPC decoder: start strobe, received word,
// parity-check matrix, and the decoded result with its status flags.
interface ldpc_bitflip_decode_if #(
    parameter int N        = 11,
    parameter int K        = 6,
    parameter int MAX_ITER = 8
) ();
    localparam int M  = N - K;
    localparam int IW = $clog2(MAX_ITER + 1);

    logic            i_en;
    logic [N-1:0]    codeword_in;
    logic [M*N-1:0]  parity_check;
    logic [K-1:0]    info_bits;
    logic            o_valid;
    logic            o_success;
    logic            o_busy;
    logic [IW-1:0]   iter_count;

    // Requester side: issues words and H, observes results.
    modport master (
        output i_en, codeword_in, parity_check,
        input  info_bits, o_valid, o_success, o_busy, iter_count
    );

    // Decoder side.
    modport slave (
        input  i_en, codeword_in, parity_check,
        output info_bits, o_valid, o_success, o_busy, iter_count
    );
endinterface

// File: rtl/ldpc_bitflip_decode.sv
// Hard-decision Gallager bit-flipping decoder. Latches one received word and
// H, then alternates syndrome check and flip passes until the syndrome is
// zero or the iteration budget is spent. Reports the K systematic bits.
module ldpc_bitflip_decode #(
    parameter int N        = 11,
    parameter int K        = 6,
    parameter int MAX_ITER = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ldpc_bitflip_decode_if.slave bus
);
    localparam int M  = N - K;
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int UW = $clog2(M + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYND,
        S_FLIP,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    c;
    logic [M*N-1:0]  h;
    logic [IW-1:0]   iter;
    logic [M-1:0]    s;
    logic [UW-1:0]   u [N];
    logic [UW-1:0]   umax;
    logic [N-1:0]    flip_mask;

    logic [K-1:0]    info_q;
    logic            valid_q;
    logic            success_q;
    logic            busy_q;
    logic [IW-1:0]   iter_count_q;

    // Syndrome of the working word against the latched H (row r is the
    // r-th N-bit slice counted from the top of the flattened vector).
    always_comb begin
        // NOTE: every combinational output gets a default before any branch
        // or loop writes it, so no path can leave it unassigned (no latch).
        s = '0;
        for (int r = 0; r < M; r++) begin
            s[r] = ^(c & h[(M-r)*N-1 -: N]);
        end
    end

    // Per-bit unsatisfied-check count: failing checks that touch bit j.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            u[j] = '0;
            for (int r = 0; r < M; r++) begin
                u[j] = u[j] + UW'(s[r] & h[(M-r-1)*N + j]);
            end
        end
    end

    // Largest count and the mask of every bit that reaches it (ties flip together).
    always_comb begin
        umax      = '0;
        flip_mask = '0;
        for (int j = 0; j < N; j++) begin
            if (u[j] > umax) umax = u[j];
        end
        for (int j = 0; j < N; j++) begin
            flip_mask[j] = (u[j] == umax) && (umax != '0);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.i_en) state_nxt = S_SYND;
            S_SYND: begin
                if (s == '0)                     state_nxt = S_DONE;
                else if (iter == IW'(MAX_ITER))  state_nxt = S_DONE;
                else                             state_nxt = S_FLIP;
            end
            S_FLIP: state_nxt = S_SYND;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        // NOTE: the working word and latched H are cleared on reset as well,
        // so an aborted decode leaves nothing behind that could leak out.
        if (!rst_n) begin
            c            <= '0;
            h            <= '0;
            iter         <= '0;
            info_q       <= '0;
            valid_q      <= 1'b0;
            success_q    <= 1'b0;
            busy_q       <= 1'b0;
            iter_count_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy_q <= bus.i_en;
                    if (bus.i_en) begin
                        c    <= bus.codeword_in;
                        h    <= bus.parity_check;
                        iter <= '0;
                    end
                end
                S_SYND: busy_q <= 1'b1;
                S_FLIP: begin
                    busy_q <= 1'b1;
                    c      <= c ^ flip_mask;
                    iter   <= iter + IW'(1);
                end
                S_DONE: begin
                    // c is untouched since SYND, so s still reflects the final word.
                    busy_q       <= 1'b1;
                    info_q       <= c[N-1 -: K];
                    success_q    <= (s == '0);
                    iter_count_q <= iter;
                    valid_q      <= 1'b1;
                end
                default: busy_q <= 1'b0;
            endcase
        end
    end

    assign bus.info_bits  = info_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_success  = success_q;
    assign bus.o_busy     = busy_q;
    assign bus.iter_count = iter_count_q;

endmodule

// File: tb/tb_ldpc_bitflip_decode.sv
// Testbench for ldpc_bitflip_decode: table of words with expected results fed
// through a scoreboard, plus hand sequences for H latching, back-to-back
// starts and reset mid-decode.
module tb_ldpc_bitflip_decode;
    localparam int N        = 11;
    localparam int K        = 6;
    localparam int MAX_ITER = 8;
    localparam int M        = N - K;
    localparam int NV       = 7;

    typedef struct {
        string          name;
        logic [M*N-1:0] h;
        logic [N-1:0]   cw;
        logic           ok;
        int             iters;
        logic [K-1:0]   info;
    } vec_t;

    typedef struct {
        string        name;
        logic         ok;
        int           iters;
        logic [K-1:0] info;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    vec_t vecs [NV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ldpc_bitflip_decode_if #(.N(N), .K(K), .MAX_ITER(MAX_ITER)) bus ();

    ldpc_bitflip_decode #(.N(N), .K(K), .MAX_ITER(MAX_ITER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [M*N-1:0] make_diag();
        logic [M*N-1:0] hh  = '0;
        logic [N-1:0]   one = 1;
        for (int r = 0; r < M; r++) hh[(M-r)*N-1 -: N] = one << (N - 1 - r);
        return hh;
    endfunction

    // Result monitor: every o_valid must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            exp_t e;
            check("valid_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.name, "_info"},    64'(bus.info_bits),  64'(e.info));
                check({e.name, "_success"}, 64'(bus.o_success),  64'(e.ok));
                check({e.name, "_iter"},    64'(bus.iter_count), 64'(e.iters));
                check({e.name, "_latency"}, 64'(cyc),            64'(e.cyc));
            end
        end
    end

    task automatic push_exp(input vec_t v, input int cap_cyc);
        exp_t e;
        e.name  = v.name;
        e.ok    = v.ok;
        e.iters = v.iters;
        e.info  = v.info;
        e.cyc   = cap_cyc + 2 + 2 * v.iters;
        sb.push_back(e);
    endtask

    // One-cycle start pulse; returns at the negedge after the capture edge.
    task automatic start(input vec_t v);
        @(negedge clk);
        bus.codeword_in  = v.cw;
        bus.parity_check = v.h;
        bus.i_en         = 1'b1;
        push_exp(v, cyc + 1);
        @(negedge clk);
        bus.i_en = 1'b0;
        check({v.name, "_busy_start"}, 64'(bus.o_busy), 64'(1));
    endtask

    // Bounded wait for all expected results, then check busy dropped.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        check({name, "_drained"}, 64'(sb.size()), 64'(0));
        sb.delete();
        @(negedge clk);
        check({name, "_busy_end"}, 64'(bus.o_busy), 64'(0));
    endtask

    task automatic check_zero(input string name);
        check({name, "_info"},    64'(bus.info_bits),  64'(0));
        check({name, "_valid"},   64'(bus.o_valid),    64'(0));
        check({name, "_success"}, 64'(bus.o_success),  64'(0));
        check({name, "_busy"},    64'(bus.o_busy),     64'(0));
        check({name, "_iter"},    64'(bus.iter_count), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [M*N-1:0] diag;
        int             base;
        diag = make_diag();
        vecs[0] = '{"clean",    diag, 11'b00000000000, 1'b1, 0, 6'b000000};
        vecs[1] = '{"single",   diag, 11'b10000000000, 1'b1, 1, 6'b000000};
        vecs[2] = '{"double",   diag, 11'b10010000000, 1'b1, 1, 6'b000000};
        vecs[3] = '{"oscill",   {11'b00000000011, 44'b0}, 11'b00000000001, 1'b0, MAX_ITER, 6'b000000};
        vecs[4] = '{"unchk",    diag, 11'b00000100000, 1'b1, 0, 6'b000001};
        vecs[5] = '{"allfive",  diag, 11'b11111000000, 1'b1, 1, 6'b000000};
        vecs[6] = '{"mixed",    diag, 11'b01000100001, 1'b1, 1, 6'b000001};

        bus.i_en         = 1'b0;
        bus.codeword_in  = '0;
        bus.parity_check = '0;
        rst_n            = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            start(vecs[i]);
            wait_idle(vecs[i].name);
            @(negedge clk);
        end

        // H and word latched at capture; a start during FLIP is ignored.
        start(vecs[1]);
        bus.parity_check = '1;
        bus.codeword_in  = '1;
        @(negedge clk);
        check("latch_busy_flip", 64'(bus.o_busy), 64'(1));
        bus.i_en = 1'b1;
        @(negedge clk);
        bus.i_en = 1'b0;
        wait_idle("latch");

        // i_en held high through DONE restarts immediately.
        @(negedge clk);
        bus.codeword_in  = '0;
        bus.parity_check = diag;
        bus.i_en         = 1'b1;
        base = cyc + 1;
        push_exp(vecs[0], base);
        push_exp(vecs[0], base + 3);
        repeat (3) @(negedge clk);
        check("b2b_busy_valid", 64'(bus.o_busy), 64'(1));
        @(negedge clk);
        bus.i_en = 1'b0;
        check("b2b_busy_restart", 64'(bus.o_busy), 64'(1));
        wait_idle("b2b");

        // Reset while in FLIP of the oscillating case: no result posted.
        start(vecs[3]);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("abort");
        sb.delete();
        repeat (25) @(negedge clk);
        check("abort_idle_busy", 64'(bus.o_busy), 64'(0));
        start(vecs[0]);
        wait_idle("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
